rr_arbiter4: RTL and testbench
==============================

Name: rr_arbiter4

Overview:
- Round-robin arbiter that shares one resource among 4 requesters.
- Grant is produced as a 2-bit index `gnt_idx`; `gnt` is the one-hot 2-to-4 decode of that index, qualified by `gnt_valid`.
- Adds fairness (rotating priority), grant hold/release handshake, and a hold-time limit that forces preemption.
- Sits in front of any shared datapath resource (bus, memory port, ALU) as its access controller.

Parameters:
- MAX_HOLD, 8, max consecutive cycles a grant is held while other requesters wait; legal range 1..2^CW-1.
- CW, 4, width of the hold counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  4  request vector; req[i]=1 means requester i wants the resource.
- done  input  1  current owner releases the resource; ignored when no grant is active.
- gnt  output  4  one-hot grant, the decode of gnt_idx; all zero when gnt_valid=0.
- gnt_idx  output  2  index of the granted requester; 0 when gnt_valid=0.
- gnt_valid  output  1  a grant is active.

Behaviour:
- All outputs are registered; no combinational path from req or done to any output.
- Reset (sync, active-high, sampled on clk edge):
  - state=IDLE, ptr=0, cnt=0.
  - gnt=0000, gnt_idx=00, gnt_valid=0.
  - Reset asserted mid-grant drops the grant at that edge; no pending state survives.
- FSM states: IDLE, GRANT.
- IDLE:
  - If req==0000, stay in IDLE.
  - Otherwise the winner w is the first i with req[i]=1, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - At the edge: gnt_idx<=w, gnt_valid<=1, gnt<=decode(w), ptr<=(w+1) mod 4, cnt<=0, state<=GRANT.
- Latency: req sampled at edge k produces a grant visible after edge k+1, i.e. 1 cycle.
- GRANT: release at the edge when any of these holds:
  - (a) done=1;
  - (b) req[gnt_idx]=0, i.e. the owner dropped its request;
  - (c) cnt==MAX_HOLD-1 and (req & ~gnt)!=0, i.e. hold limit reached and another requester is waiting.
- On release: gnt<=0000, gnt_idx<=00, gnt_valid<=0, state<=IDLE.
  - Exactly one IDLE cycle (gnt_valid=0) separates consecutive grants, even when requests are pending.
- No release: cnt<=cnt+1, saturating at MAX_HOLD-1.
  - With no other requester waiting, the owner keeps the grant indefinitely; cnt stays at MAX_HOLD-1.
  - A new competing request then forces release on the next edge.
- Simultaneous done and hold-limit: a single release; behaviour is identical.
- ptr advances only when a grant is issued, never on release or preemption.
  - A preempted owner therefore gets lowest priority next round.
- ptr wraps 3->0.
- MAX_HOLD=1: with competitors waiting, every grant lasts exactly 1 cycle.
- Invariants, checked every cycle:
  - gnt==decode(gnt_idx) when gnt_valid=1, otherwise 0000.
  - At most one bit of gnt is set.
  - gnt_valid==(state==GRANT).

Test Plan:
- Reset: rst=1 for 2 cycles with req=1111 -> gnt=0000, gnt_valid=0, gnt_idx=00. Release rst with req=1111 -> 1 cycle later gnt=0001, gnt_idx=00.
- Single requester: req=0100 from cycle 0 -> gnt=0100 from cycle 1. done pulse at cycle 5 -> gnt=0000 at cycle 6, gnt=0100 again at cycle 7 (ptr=3, only req[2] set).
- Round-robin fairness: req=1111 held, done pulsed each cycle of grant -> grant order idx 0,1,2,3,0 with one idle cycle between each; gnt_valid pattern 1,0,1,0,...
- Preemption, MAX_HOLD=8: req=0011, owner 0 never asserts done -> gnt=0001 for exactly 8 cycles, 1 idle cycle, then gnt=0010. Repeat with req=0001 only -> grant held for 20+ cycles with no drop.
- Request drop and wrap: owner idx 3 (ptr=0 after grant), req[3] falls while req=0110 -> release next edge, then grant idx 1.
- Mid-operation reset: grant active on idx 2, rst=1 for 1 cycle -> all outputs 0 next cycle; after rst=0 with req=1100 -> grant idx 2 (ptr reset to 0, search 0,1,2).

Source files
------------

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with a registered one-hot/index grant, a done/release
// handshake and a hold-time limit that preempts an owner while others are waiting.
module rr_arbiter4 #(
    parameter int MAX_HOLD = 8,
    parameter int CW       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    logic [0:0]    state;
    logic [1:0]    ptr;
    logic [CW-1:0] cnt;

    logic          win_found;
    logic [1:0]    win_idx;
    logic          owner_req;
    logic          others_wait;
    logic          hold_expired;
    logic          release_now;

    // First requester at or after ptr, wrapping modulo 4.
    function automatic logic [2:0] find_winner(input logic [3:0] r, input logic [1:0] p);
        logic       found;
        logic [1:0] idx;
        logic [1:0] cand;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = p + 2'(k);
            if (!found && r[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [3:0] decode2to4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    always_comb begin
        {win_found, win_idx} = find_winner(req, ptr);
        owner_req    = req[gnt_idx];
        others_wait  = (req & ~gnt) != 4'b0000;
        hold_expired = (cnt == HOLD_LAST) && others_wait;
        release_now  = done || !owner_req || hold_expired;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            cnt       <= '0;
            gnt       <= 4'b0000;
            gnt_idx   <= 2'd0;
            gnt_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state     <= GRANT;
                        gnt_idx   <= win_idx;
                        gnt       <= decode2to4(win_idx);
                        gnt_valid <= 1'b1;
                        ptr       <= win_idx + 2'd1;
                        cnt       <= '0;
                    end
                end
                GRANT: begin
                    // ptr is left alone on release so a preempted owner ranks last next round.
                    if (release_now) begin
                        state     <= IDLE;
                        gnt       <= 4'b0000;
                        gnt_idx   <= 2'd0;
                        gnt_valid <= 1'b0;
                    end else if (cnt != HOLD_LAST) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= 4'b0000;
                    gnt_idx   <= 2'd0;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: each step drives inputs, queues the grant expected
// after the next rising edge, then pops and compares it just after that edge.
module tb_rr_arbiter4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;

    typedef struct {
        logic       valid;
        logic [1:0] idx;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    rr_arbiter4 #(.MAX_HOLD(8), .CW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic r_rst, input logic [3:0] r_req, input logic r_done,
                        input logic e_valid, input logic [1:0] e_idx, input string tag);
        exp_t e;
        exp_t got;
        logic [3:0] e_gnt;
        rst  = r_rst;
        req  = r_req;
        done = r_done;
        e.valid = e_valid;
        e.idx   = e_valid ? e_idx : 2'd0;
        e.tag   = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got   = exp_q.pop_front();
        e_gnt = got.valid ? (4'b0001 << got.idx) : 4'b0000;
        checks++;
        assert (gnt_valid === got.valid) else begin
            errors++;
            $error("FAIL %s gnt_valid observed %b expected %b", got.tag, gnt_valid, got.valid);
        end
        checks++;
        assert (gnt_idx === got.idx) else begin
            errors++;
            $error("FAIL %s gnt_idx observed %0d expected %0d", got.tag, gnt_idx, got.idx);
        end
        checks++;
        assert (gnt === e_gnt) else begin
            errors++;
            $error("FAIL %s gnt observed %b expected %b", got.tag, gnt, e_gnt);
        end
        checks++;
        assert ($countones(gnt) <= 1) else begin
            errors++;
            $error("FAIL %s_onehot gnt observed %b expected at most one bit", got.tag, gnt);
        end
        @(negedge clk);
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;
        @(negedge clk);

        // Reset with all requesting, then release into fairness rotation.
        step(1, 4'b1111, 0, 0, 0, "reset0");
        step(1, 4'b1111, 0, 0, 0, "reset1");
        step(0, 4'b1111, 0, 1, 0, "first_grant");
        step(0, 4'b1111, 1, 0, 0, "rr_rel0");
        step(0, 4'b1111, 0, 1, 1, "rr_g1");
        step(0, 4'b1111, 1, 0, 0, "rr_rel1");
        step(0, 4'b1111, 0, 1, 2, "rr_g2");
        step(0, 4'b1111, 1, 0, 0, "rr_rel2");
        step(0, 4'b1111, 0, 1, 3, "rr_g3");
        step(0, 4'b1111, 1, 0, 0, "rr_rel3");
        step(0, 4'b1111, 0, 1, 0, "rr_wrap0");
        step(0, 4'b1111, 1, 0, 0, "rr_rel4");

        // Single requester: hold without competition, release by done, regrant.
        step(1, 4'b0000, 0, 0, 0, "reset2");
        step(0, 4'b0100, 0, 1, 2, "single_g");
        for (int i = 0; i < 4; i++) step(0, 4'b0100, 0, 1, 2, "single_hold");
        step(0, 4'b0100, 1, 0, 0, "single_done");
        step(0, 4'b0100, 0, 1, 2, "single_regrant");
        step(0, 4'b0100, 1, 0, 0, "single_rel");

        // Hold limit: ptr=3, req=0011 -> owner 0 for exactly 8 cycles, then owner 1.
        step(0, 4'b0011, 0, 1, 0, "pre_g0");
        for (int i = 0; i < 7; i++) step(0, 4'b0011, 0, 1, 0, "pre_hold");
        step(0, 4'b0011, 0, 0, 0, "pre_release");
        step(0, 4'b0011, 0, 1, 1, "pre_g1");
        step(0, 4'b0001, 0, 0, 0, "owner1_drop");

        // Lone owner keeps grant indefinitely; a late competitor preempts at once.
        step(0, 4'b0001, 0, 1, 0, "lone_g0");
        for (int i = 0; i < 22; i++) step(0, 4'b0001, 0, 1, 0, "lone_hold");
        step(0, 4'b0011, 0, 0, 0, "late_competitor");
        step(0, 4'b0011, 0, 1, 1, "late_g1");
        step(0, 4'b0011, 1, 0, 0, "late_rel");

        // Owner 3 drops its request (ptr wraps to 0), then idx 1 wins.
        step(0, 4'b1000, 0, 1, 3, "wrap_g3");
        step(0, 4'b0110, 0, 0, 0, "wrap_drop");
        step(0, 4'b0110, 0, 1, 1, "wrap_g1");
        step(0, 4'b0110, 1, 0, 0, "wrap_rel");

        // Mid-grant reset clears ptr, so req=1100 picks idx 2.
        step(0, 4'b0100, 0, 1, 2, "mid_g2");
        step(1, 4'b0100, 0, 0, 0, "mid_reset");
        step(0, 4'b1100, 0, 1, 2, "post_reset_g2");

        // done is ignored while idle.
        step(0, 4'b0100, 1, 0, 0, "idle_rel");
        step(0, 4'b0001, 1, 1, 0, "idle_done_ignored");
        step(0, 4'b0001, 1, 0, 0, "idle_rel2");

        // done coinciding with the hold limit gives a single release.
        step(0, 4'b0011, 0, 1, 1, "both_g1");
        for (int i = 0; i < 7; i++) step(0, 4'b0011, 0, 1, 1, "both_hold");
        step(0, 4'b0011, 1, 0, 0, "both_release");
        step(0, 4'b0011, 0, 1, 0, "both_next_g0");

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL queue_drain leftover %0d expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed no finish expected completion");
        $fatal(1, "timeout");
    end

endmodule
